// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes and phase type for the 32-point MDC FFT front end.
package fft_pkg;
  localparam int FFT_N    = 32;
  localparam int FFT_HALF = 16;
  localparam int CNT_W    = 5;
  localparam int IDX_W    = 4;
  localparam int SAMPLE_W = 9;
  typedef enum logic {PH_FILL, PH_PAIR} phase_e;
endpackage

// File: rtl/fft_half_buffer.sv
// fft_half_buffer: 16-entry sample store, synchronous write, asynchronous read.
module fft_half_buffer
  import fft_pkg::*;
#(
  parameter int DW = 2 * SAMPLE_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [DW-1:0]    rd_data
);
  logic [DW-1:0] mem_q [FFT_HALF];
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_addr] <= wr_data;
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/fft_input_stage.sv
// fft_input_stage: buffers the first half-frame and emits (x[k], x[k+16]) pairs.
module fft_input_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_up_re,
  output logic [WIDTH-1:0] out_up_im,
  output logic [WIDTH-1:0] out_lo_re,
  output logic [WIDTH-1:0] out_lo_im,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last
);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   wr_addr, idx_q;
  logic [2*WIDTH-1:0] rd_data, up_q, lo_q;
  logic               wr_en, pair, valid_q, last_q;
  phase_e             phase;
  always_comb begin
    phase   = cnt_q[CNT_W-1] ? PH_PAIR : PH_FILL;
    pair    = in_valid && !in_first && phase == PH_PAIR;
    wr_en   = in_valid && (in_first || phase == PH_FILL);
    wr_addr = in_first ? '0 : cnt_q[IDX_W-1:0];
    // in_first restarts the frame with this sample already stored at index 0
    cnt_d   = !in_valid ? cnt_q : in_first ? CNT_W'(1) : cnt_q + 1'b1;
  end
  fft_half_buffer #(.DW(2 * WIDTH)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_addr (cnt_q[IDX_W-1:0]),
    .rd_data (rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      up_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= pair;
      last_q  <= pair && cnt_q == CNT_W'(FFT_N - 1);
      if (pair) begin
        idx_q <= cnt_q[IDX_W-1:0];
        up_q  <= rd_data;
        lo_q  <= {in_re, in_im};
      end
    end
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_index = idx_q;
  assign {out_up_re, out_up_im} = up_q;
  assign {out_lo_re, out_lo_im} = lo_q;
endmodule

// File: tb/tb_fft_input_stage.sv
// tb_fft_input_stage: directed frames checked against a frame-array model every cycle.
module tb_fft_input_stage;
  localparam int W = 9;
  logic clk = 0, rst_n = 0, in_valid = 0, in_first = 0;
  logic [W-1:0] in_re = '0, in_im = '0;
  logic out_valid, out_last;
  logic [W-1:0] out_up_re, out_up_im, out_lo_re, out_lo_im;
  logic [3:0] out_index;
  int checks = 0, fails = 0;
  fft_input_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
    .out_up_re(out_up_re), .out_up_im(out_up_im),
    .out_lo_re(out_lo_re), .out_lo_im(out_lo_im),
    .out_index(out_index), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic check(string nm, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask
  // model: position n within the current frame and the samples seen so far
  int n = 0;
  logic [2*W-1:0] fr [32];
  logic [2*W-1:0] e_up = '0, e_lo = '0;
  logic [3:0] e_idx = '0;
  logic e_valid = 0, e_last = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n = 0; e_up = '0; e_lo = '0; e_idx = '0; e_valid = 0; e_last = 0;
    end else begin
      e_valid = 0;
      e_last  = 0;
      if (in_valid) begin
        if (in_first) n = 0;
        fr[n] = {in_re, in_im};
        if (n >= 16) begin
          e_valid = 1;
          e_last  = (n == 31);
          e_idx   = 4'(n - 16);
          e_up    = fr[n-16];
          e_lo    = fr[n];
        end
        n = (n + 1) % 32;
      end
    end
  always @(negedge clk)
    if (rst_n) begin
      check("valid", W'(out_valid), W'(e_valid));
      check("last", W'(out_last), W'(e_last));
      check("index", W'(out_index), W'(e_idx));
      check("up_re", out_up_re, e_up[2*W-1:W]);
      check("up_im", out_up_im, e_up[W-1:0]);
      check("lo_re", out_lo_re, e_lo[2*W-1:W]);
      check("lo_im", out_lo_im, e_lo[W-1:0]);
    end
  task automatic step(logic v, logic f, int re, int im);
    in_valid = v; in_first = f; in_re = W'(re); in_im = W'(im);
    @(posedge clk);
    #1;
    in_valid = 0; in_first = 0;
  endtask
  task automatic frame(int base, int len, bit first, bit gap);
    for (int i = 0; i < len; i++) begin
      if (gap && i % 3 == 2) step(0, 0, 0, 0);
      step(1, first && i == 0, base + i, -(base + i));
    end
  endtask
  task automatic zeros(string nm);
    check({nm, "_v"}, W'(out_valid), '0);
    check({nm, "_l"}, W'(out_last), '0);
    check({nm, "_i"}, W'(out_index), '0);
    check({nm, "_ur"}, out_up_re, '0);
    check({nm, "_ui"}, out_up_im, '0);
    check({nm, "_lr"}, out_lo_re, '0);
    check({nm, "_li"}, out_lo_im, '0);
  endtask
  initial begin
    #12 zeros("rst");
    #5 rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      step(1, i == 0, i, -i);
      if (i == 15) check("fill_nv", W'(out_valid), '0);
      if (i == 16) begin
        check("p0_up_re", out_up_re, 9'h000);
        check("p0_lo_re", out_lo_re, 9'h010);
        check("p0_lo_im", out_lo_im, 9'h1F0);
        check("p0_idx", W'(out_index), 9'h000);
      end
      if (i == 31) begin
        check("p15_idx", W'(out_index), 9'h00F);
        check("p15_last", W'(out_last), 9'h001);
        check("p15_up_im", out_up_im, 9'h1F1);
        check("p15_lo_re", out_lo_re, 9'h01F);
      end
    end
    step(0, 0, 0, 0);
    check("post_nv", W'(out_valid), '0);
    check("hold_lo_re", out_lo_re, 9'h01F);
    frame(0, 32, 1, 1);
    frame(0, 32, 1, 0);
    frame(100, 16, 1, 0);
    step(1, 0, 116, -116);
    check("f2_up_re", out_up_re, 9'd100);
    check("f2_lo_re", out_lo_re, 9'd116);
    frame(117, 15, 0, 0);
    frame(200, 20, 1, 0);
    frame(0, 32, 1, 0);
    frame(30, 24, 1, 0);
    check("k7_idx", W'(out_index), 9'h007);
    #2 rst_n = 0;
    #1 zeros("arst");
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    frame(50, 32, 0, 0);
    check("nofirst_lo", out_lo_re, 9'd81);
    for (int i = 0; i < 32; i++) step(1, i == 0, -256, 255);
    check("ext_up_re", out_up_re, 9'h100);
    check("ext_lo_im", out_lo_im, 9'h0FF);
    frame(10, 31, 1, 0);
    step(1, 1, 7, 8);
    check("first31_nv", W'(out_valid), '0);
    check("first31_nl", W'(out_last), '0);
    frame(0, 2, 0, 0);
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/fft_input_stage.md
# fft_input_stage

Front end of the 32-point MDC FFT. It accepts one complex sample per valid cycle in natural order and holds the first half-frame (samples 0..15). During the second half-frame it emits pairs (x[k], x[k+16]) on two parallel streams, together with the pair index k. These outputs drive the upper/lower inputs and the ROM16 twiddle index of the first butterfly stage.

## Interface
Parameters:
- WIDTH, 9, bit width of each real/imag sample component (two's complement)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_re/in_im carry a sample this cycle
- in_first  in  1  qualifies sample as index 0 of a new frame (only sampled when in_valid=1)
- in_re  in  WIDTH  sample real part, signed
- in_im  in  WIDTH  sample imag part, signed
- out_valid  out  1  pair outputs valid this cycle
- out_up_re  out  WIDTH  x[k] real (first half-frame sample)
- out_up_im  out  WIDTH  x[k] imag
- out_lo_re  out  WIDTH  x[k+16] real (current sample)
- out_lo_im  out  WIDTH  x[k+16] imag
- out_index  out  4  pair index k, 0..15, used directly as ROM16 address
- out_last  out  1  high with out_valid when k=15 (frame complete)

## Operation
- Clock and reset are fixed: one clock clk; rst_n asynchronous, active-low.
- Internal 5-bit sample counter cnt. The counter advances only on in_valid. Two states are derived:
  - FILL: cnt<16.
  - PAIR: cnt>=16.
- FILL, in_valid=1: write sample into buffer[cnt[3:0]]; cnt+1; out_valid=0 next cycle.
- PAIR, in_valid=1:
  - Register out_up = buffer[cnt[3:0]] and out_lo = current input.
  - out_index=cnt[3:0], out_valid=1.
  - out_last=(cnt==31).
  - cnt+1, with 31 wrapping to 0 (back to FILL).
- in_valid=0: cnt and buffer hold; out_valid=0 next cycle; data outputs hold their last values.
- in_first=1 with in_valid=1, in any state:
  - Abandon the partial frame.
  - Write the sample to buffer[0] and set cnt=1.
  - No output pair for that cycle.
  - This also applies if in_first coincides with cnt==31: that sample becomes index 0 and no pair or out_last is emitted.
- in_first with in_valid=0 is ignored.
- No backpressure: the consumer must accept every out_valid cycle.
- Pure data movement: no arithmetic, scaling or sign change; the bit pattern passes through unchanged.
- Buffer entries are written before they are read within a frame, so buffer contents need no reset.

## Timing
- Latency: input of sample k+16 at edge t produces the pair at outputs after edge t (one register stage).
- Throughput: one sample per cycle with no bubbles. Back-to-back frames are supported; sample 0 of frame n+1 may follow sample 31 of frame n on the next cycle.
- Reset values:
  - out_valid=0, out_last=0, out_index=0.
  - All data outputs 0.
  - cnt=0 (FILL).
- Reset mid-frame (asynchronous): all outputs clear immediately and cnt=0. The first valid sample after release is treated as index 0 whether or not in_first is high.
- out_valid, out_last and out_index change only on clk edges after reset release.

## Structure
- Shared package fft_pkg:
  - FFT_N=32, FFT_HALF=16, CNT_W=5, IDX_W=4.
  - Sample width default 9.
  - Phase enum {PH_FILL, PH_PAIR} if coded as an explicit state.
- One sub-module, fft_half_buffer: 16-entry by 2*WIDTH register file with synchronous write and an asynchronous read port addressed by a 4-bit index. The top level holds the counter, phase logic and output registers.

## Test plan
- Reset then one frame with in_re=n, in_im=-n for n=0..31, in_first on n=0, in_valid continuous: 16 pairs with out_up=(k,-k), out_lo=(k+16,-(k+16)), out_index=k, out_last only at k=15. Zero out_valid during the fill.
- Same frame with in_valid dropped every third cycle: identical pair sequence, with out_valid gaps mirroring the input gaps one cycle later.
- Two back-to-back frames, second frame values n+100: second frame's pairs are (k+100, k+116) with no stale data from the first frame.
- in_first asserted at sample 20 of a frame, then a full 32-sample frame: 4 pairs from the aborted frame (k=0..3), then a clean 16-pair frame. No out_last for the aborted frame.
- rst_n pulsed low mid-PAIR (k=7): outputs go to 0 asynchronously; the next 32 samples after release form a correct frame with no in_first.
- Extreme values: in_re=-256, in_im=255 across all samples: outputs carry the bit patterns unchanged.
